// File: rtl/sha_stream_adapter.sv
// Byte-stream adapter around the SHA top: packs NL input bytes into the message array,
// starts the core, captures the digest and streams it out MSB-byte first.
module sha_stream_adapter #(
    parameter int unsigned NL = 64,
    parameter int unsigned NK = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [NL-1:0][7:0]   core_data,
    output logic                 core_enable,
    input  logic [NK-1:0]        core_hash,
    input  logic                 core_ready,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy
);

    localparam int unsigned NB = NK / 8;
    localparam int unsigned WW = (NL > 1) ? $clog2(NL) : 1;
    localparam int unsigned RW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [WW-1:0] WLast = WW'(NL - 1);
    localparam logic [RW-1:0] RLast = RW'(NB - 1);

    typedef enum logic [1:0] {StFill, StStart, StWait, StDrain} state_t;

    state_t               state_q;
    logic [WW-1:0]        wr_ptr_q;
    logic [RW-1:0]        rd_ptr_q;
    logic [NL-1:0][7:0]   msg_q;
    logic [NK-1:0]        hash_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StFill;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            msg_q    <= '0;
            hash_q   <= '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (s_valid) begin
                        msg_q[wr_ptr_q] <= s_data;
                        if (wr_ptr_q == WLast) begin
                            wr_ptr_q <= '0;
                            state_q  <= StStart;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                end
                // Ready seen here may be left over from the previous message.
                StStart: state_q <= StWait;
                StWait: begin
                    if (core_ready) begin
                        hash_q   <= core_hash;
                        rd_ptr_q <= '0;
                        state_q  <= StDrain;
                    end
                end
                StDrain: begin
                    if (m_ready) begin
                        if (rd_ptr_q == RLast) begin
                            rd_ptr_q <= '0;
                            state_q  <= StFill;
                        end else begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    // Outputs are pure state decodes, forced low while reset is applied.
    always_comb begin
        s_ready     = rst && (state_q == StFill);
        core_enable = rst && (state_q == StStart);
        m_valid     = rst && (state_q == StDrain);
        busy        = rst && (state_q != StFill);
        m_last      = m_valid && (rd_ptr_q == RLast);
        m_data      = hash_q[8 * (NB - 1 - int'(rd_ptr_q)) +: 8];
        core_data   = msg_q;
    end

endmodule
